plic_claim_agent: RTL and testbench
===================================

Name: plic_claim_agent

Overview:
- Hart-side initiator for the platform interrupt controller's claim/complete protocol; one instance per interrupt target.
- On the external-interrupt-pending level (`eip_i`) it reads the target's claim/complete register over the 32-bit register bus and presents the claimed source ID to a local handler.
- When the handler signals done, it writes the same ID back to the claim/complete register to complete the interrupt.
- Sits between the interrupt controller's register interface and an accelerator or firmware-less handler that cannot issue bus cycles itself.

Parameters:
- `BASE_ADDR`, 32'h0C00_0000, controller base address.
- `TARGET_ID`, 0, target index; claim/complete address = `BASE_ADDR` + 32'h0020_0004 + `TARGET_ID`*32'h1000.
- `SRCW`, 5, width of the source ID field; supports up to 2^`SRCW`-1 sources.
- `HOLDOFF`, 2, idle cycles after a completion write before `eip_i` is sampled again (covers controller gateway/target latency); minimum 1.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `eip_i`  in  1  external interrupt pending level from the controller for this target.
- `enable_i`  in  1  agent enable; when 0, no new claim is started.
- `reg_valid_o`  out  1  bus request valid.
- `reg_write_o`  out  1  1 = write, 0 = read.
- `reg_addr_o`  out  32  bus address.
- `reg_wdata_o`  out  32  write data; the completion ID, zero-extended.
- `reg_wstrb_o`  out  4  byte strobes; 4'hF on writes, 4'h0 on reads.
- `reg_ready_i`  in  1  bus response handshake.
- `reg_rdata_i`  in  32  read data, valid when `reg_ready_i`=1.
- `reg_error_i`  in  1  bus error, valid when `reg_ready_i`=1.
- `irq_valid_o`  out  1  claimed ID available to the handler.
- `irq_id_o`  out  `SRCW`  claimed source ID.
- `irq_ready_i`  in  1  handler accepts the ID.
- `done_i`  in  1  single-cycle pulse: handler finished servicing the ID.
- `busy_o`  out  1  high in any state other than IDLE/HOLD.
- `err_o`  out  1  sticky bus-error flag.
- `err_clr_i`  in  1  clears `err_o`.

Behaviour:
- Reset values: all outputs 0; state = IDLE; ID register = 0; holdoff counter = 0.
- States: IDLE, CLAIM, DISPATCH, SERVICE, COMPLETE, HOLD.
- IDLE:
  - if `eip_i` && `enable_i`, go to CLAIM next cycle.
  - `eip_i` is sampled registered-free but acted on only in IDLE.
- CLAIM:
  - drive `reg_valid_o`=1, `reg_write_o`=0, `reg_addr_o`=claim address.
  - Request fields are held stable until the cycle with `reg_ready_i`=1.
  - On `reg_ready_i`: if `reg_error_i`, set `err_o` and go to HOLD.
  - Else if `reg_rdata_i[SRCW-1:0]`==0 (spurious claim), go to HOLD with no write.
  - Else latch the ID and go to DISPATCH.
  - Upper `rdata` bits are ignored.
- DISPATCH:
  - `irq_valid_o`=1 with `irq_id_o`=latched ID, both stable until `irq_ready_i`.
  - Valid/ready handshake; on `irq_ready_i`, go to SERVICE.
- SERVICE: wait for `done_i`; `done_i` in any other state is ignored.
- COMPLETE:
  - `reg_valid_o`=1, `reg_write_o`=1, same address, `reg_wdata_o`={0, ID}, `reg_wstrb_o`=4'hF.
  - On `reg_ready_i`, go to HOLD; if `reg_error_i`, also set `err_o`. No retry.
- HOLD: load the counter with `HOLDOFF`-1, count down to 0, then go to IDLE. Total `HOLDOFF` cycles in HOLD.
- Latency:
  - `eip_i` rise in IDLE → `reg_valid_o` high on the next cycle.
  - `reg_ready_i` on claim → `irq_valid_o` high on the next cycle.
  - `done_i` → write `reg_valid_o` high on the next cycle.
- `enable_i` deasserted mid-operation does not abort; the current transaction completes through HOLD.
- `eip_i` falling during CLAIM does not abort the read; the controller returns 0, which is handled as spurious.
- `err_clr_i` and a new error in the same cycle: the set wins, so `err_o` stays 1.
- Asynchronous reset mid-bus-transaction drops `reg_valid_o` immediately; the bus is required to tolerate an abandoned request.
- `busy_o` = state ∈ {CLAIM, DISPATCH, SERVICE, COMPLETE}.

Optional Feature:
- Macro `PLIC_CLAIM_STATS_EN`.
- When defined, adds three 16-bit saturating counters, all reset to 0 and all cleared by `err_clr_i`:
  - `stat_claims_o`: non-zero claims.
  - `stat_spurious_o`: zero-ID claims.
  - `stat_errors_o`: bus errors.
- Each counter increments in the cycle its event is accepted and holds at 16'hFFFF.
- When undefined, the ports and logic are absent.

Test Plan:
- Basic claim/complete:
  - `TARGET_ID`=1; `eip_i`=1; bus returns `rdata`=7 after 2 wait cycles.
  - Expect a read at 32'h0C20_1004, `irq_id_o`=7, and after `done_i` a write to 32'h0C20_1004 with `wdata`=7, `wstrb`=F.
  - Expect 2 HOLD cycles, then IDLE.
- Spurious claim: `rdata`=0 → no `irq_valid_o`, no write, HOLD then IDLE; stats spurious=1 when enabled.
- Back-to-back: `eip_i` held high across two claims (IDs 3, then 5) → two full sequences separated by exactly `HOLDOFF` cycles, IDs in order.
- Handler backpressure: `irq_ready_i` low for 10 cycles → `irq_valid_o`/`irq_id_o` stable for 10 cycles; `done_i` pulsed during DISPATCH is ignored.
- Bus error on the claim read → `err_o`=1, no dispatch; `err_clr_i` → `err_o`=0. Error on the completion write → `err_o`=1, returns to IDLE.
- Reset asserted during COMPLETE with `reg_valid_o`=1 → all outputs 0 asynchronously; after release, IDLE and a fresh claim on `eip_i`.

Source files
------------

// File: rtl/plic_claim_agent.sv
// Hart-side claim/complete initiator for one interrupt target of the platform interrupt controller.
// Optional build macro PLIC_CLAIM_STATS_EN adds saturating claim/spurious/error counters.
//
// Handshake rules, used identically on both sides of this block:
//   reg_valid_o and every request field (reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o) stay
//   stable from the first valid cycle until the cycle in which reg_ready_i=1; reg_rdata_i and
//   reg_error_i are sampled only in that cycle. irq_valid_o/irq_id_o stay stable until irq_ready_i=1,
//   and the transfer happens in the cycle where both are high.
module plic_claim_agent #(
   parameter logic [31:0] BASE_ADDR = 32'h0C00_0000,
   parameter int unsigned TARGET_ID = 0,
   parameter int unsigned SRCW      = 5,
   parameter int unsigned HOLDOFF   = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            eip_i,
   input  logic            enable_i,
   output logic            reg_valid_o,
   output logic            reg_write_o,
   output logic [31:0]     reg_addr_o,
   output logic [31:0]     reg_wdata_o,
   output logic [3:0]      reg_wstrb_o,
   input  logic            reg_ready_i,
   input  logic [31:0]     reg_rdata_i,
   input  logic            reg_error_i,
   output logic            irq_valid_o,
   output logic [SRCW-1:0] irq_id_o,
   input  logic            irq_ready_i,
   input  logic            done_i,
   output logic            busy_o,
   output logic            err_o,
   input  logic            err_clr_i,
`ifdef PLIC_CLAIM_STATS_EN
   output logic [15:0]     stat_claims_o,
   output logic [15:0]     stat_spurious_o,
   output logic [15:0]     stat_errors_o,
`endif
   output logic [2:0]      dbg_state_o
);

   localparam logic [31:0] CLAIM_ADDR = BASE_ADDR + 32'h0020_0004 + 32'(TARGET_ID) * 32'h1000;
   localparam int unsigned CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CLAIM    = 3'd1,
      S_DISPATCH = 3'd2,
      S_SERVICE  = 3'd3,
      S_COMPLETE = 3'd4,
      S_HOLD     = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [SRCW-1:0]   id_q, id_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              err_set, claim_evt, spur_evt;
   logic              unused_rdata;

   assign unused_rdata = ^reg_rdata_i[31:SRCW];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         id_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      cnt_d     = cnt_q;
      err_set   = 1'b0;
      claim_evt = 1'b0;
      spur_evt  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (eip_i && enable_i) state_d = S_CLAIM;
         end
         S_CLAIM: begin
            if (reg_ready_i) begin
               if (reg_error_i) begin
                  err_set = 1'b1;
                  state_d = S_HOLD;
                  cnt_d   = CW'(HOLDOFF - 1);
               end else if (reg_rdata_i[SRCW-1:0] == '0) begin
                  spur_evt = 1'b1;
                  state_d  = S_HOLD;
                  cnt_d    = CW'(HOLDOFF - 1);
               end else begin
                  claim_evt = 1'b1;
                  id_d      = reg_rdata_i[SRCW-1:0];
                  state_d   = S_DISPATCH;
               end
            end
         end
         S_DISPATCH: begin
            if (irq_ready_i) state_d = S_SERVICE;
         end
         S_SERVICE: begin
            if (done_i) state_d = S_COMPLETE;
         end
         S_COMPLETE: begin
            if (reg_ready_i) begin
               err_set = reg_error_i;
               state_d = S_HOLD;
               cnt_d   = CW'(HOLDOFF - 1);
            end
         end
         S_HOLD: begin
            // Gives the controller's gateway time to drop eip for the completed source.
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      // A new error outranks a clear arriving in the same cycle.
      err_d = err_set | (err_q & ~err_clr_i);
   end

   always_comb begin
      reg_valid_o = 1'b0;
      reg_write_o = 1'b0;
      reg_addr_o  = '0;
      reg_wdata_o = '0;
      reg_wstrb_o = 4'h0;
      if (state_q == S_CLAIM) begin
         reg_valid_o = 1'b1;
         reg_addr_o  = CLAIM_ADDR;
      end else if (state_q == S_COMPLETE) begin
         reg_valid_o = 1'b1;
         reg_write_o = 1'b1;
         reg_addr_o  = CLAIM_ADDR;
         reg_wdata_o = 32'(id_q);
         reg_wstrb_o = 4'hF;
      end
   end

   assign irq_valid_o = (state_q == S_DISPATCH);
   assign irq_id_o    = id_q;
   assign busy_o      = (state_q == S_CLAIM) || (state_q == S_DISPATCH) ||
                        (state_q == S_SERVICE) || (state_q == S_COMPLETE);
   assign err_o       = err_q;
   assign dbg_state_o = state_q;

`ifdef PLIC_CLAIM_STATS_EN
   logic [15:0] claims_q, claims_d, spur_q, spur_d, errs_q, errs_d;

   function automatic logic [15:0] sat_next(input logic [15:0] cur, input logic evt,
                                            input logic clr);
      logic [15:0] base;
      base = clr ? 16'h0000 : cur;
      if (evt && base != 16'hFFFF) return base + 16'h0001;
      return base;
   endfunction

   always_comb begin
      claims_d = sat_next(claims_q, claim_evt, err_clr_i);
      spur_d   = sat_next(spur_q, spur_evt, err_clr_i);
      errs_d   = sat_next(errs_q, err_set, err_clr_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         claims_q <= '0;
         spur_q   <= '0;
         errs_q   <= '0;
      end else begin
         claims_q <= claims_d;
         spur_q   <= spur_d;
         errs_q   <= errs_d;
      end
   end

   assign stat_claims_o   = claims_q;
   assign stat_spurious_o = spur_q;
   assign stat_errors_o   = errs_q;
`endif

endmodule

// File: tb/tb_plic_claim_agent.sv
// Directed bench for plic_claim_agent (TARGET_ID=1): transaction-level model checked every cycle,
// an expected-ID queue for dispatched interrupts, and literal spot checks.
module tb_plic_claim_agent;

   localparam int HOLDOFF = 2;
   localparam logic [31:0] EXP_ADDR = 32'h0C20_1004;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        eip_i, enable_i, reg_ready_i, reg_error_i, irq_ready_i, done_i, err_clr_i;
   logic [31:0] reg_rdata_i;
   logic        reg_valid_o, reg_write_o, irq_valid_o, busy_o, err_o;
   logic [31:0] reg_addr_o, reg_wdata_o;
   logic [3:0]  reg_wstrb_o;
   logic [4:0]  irq_id_o;
   logic [2:0]  dbg_state_o;
`ifdef PLIC_CLAIM_STATS_EN
   logic [15:0] stat_claims_o, stat_spurious_o, stat_errors_o;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   plic_claim_agent #(
      .BASE_ADDR(32'h0C00_0000), .TARGET_ID(1), .SRCW(5), .HOLDOFF(HOLDOFF)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .eip_i(eip_i), .enable_i(enable_i),
      .reg_valid_o(reg_valid_o), .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o),
      .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o), .reg_ready_i(reg_ready_i),
      .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i), .irq_valid_o(irq_valid_o),
      .irq_id_o(irq_id_o), .irq_ready_i(irq_ready_i), .done_i(done_i), .busy_o(busy_o),
      .err_o(err_o), .err_clr_i(err_clr_i),
`ifdef PLIC_CLAIM_STATS_EN
      .stat_claims_o(stat_claims_o), .stat_spurious_o(stat_spurious_o),
      .stat_errors_o(stat_errors_o),
`endif
      .dbg_state_o(dbg_state_o)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phase of the claim/complete conversation, tracked from what the protocol rules say happens.
   localparam int M_IDLE = 0, M_READ = 1, M_OFFER = 2, M_WAIT = 3, M_WRITE = 4, M_QUIET = 5;
   int         m_ph;
   int         m_quiet_cycles;
   logic [4:0] m_id;
   logic       m_err;
   bit         m_set;
`ifdef PLIC_CLAIM_STATS_EN
   int m_claims, m_spur, m_errs;
`endif

   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         m_ph = M_IDLE; m_quiet_cycles = 0; m_id = '0; m_err = 1'b0;
`ifdef PLIC_CLAIM_STATS_EN
         m_claims = 0; m_spur = 0; m_errs = 0;
`endif
      end else begin
         m_set = 1'b0;
`ifdef PLIC_CLAIM_STATS_EN
         if (err_clr_i) begin m_claims = 0; m_spur = 0; m_errs = 0; end
`endif
         if (m_ph == M_IDLE) begin
            if (eip_i && enable_i) m_ph = M_READ;
         end else if (m_ph == M_READ) begin
            if (reg_ready_i) begin
               if (reg_error_i) begin
                  m_set = 1'b1; m_ph = M_QUIET; m_quiet_cycles = 0;
               end else if (reg_rdata_i % 32 == 0) begin
                  m_ph = M_QUIET; m_quiet_cycles = 0;
`ifdef PLIC_CLAIM_STATS_EN
                  if (m_spur < 65535) m_spur++;
`endif
               end else begin
                  m_id = 5'(reg_rdata_i % 32); m_ph = M_OFFER;
`ifdef PLIC_CLAIM_STATS_EN
                  if (m_claims < 65535) m_claims++;
`endif
               end
            end
         end else if (m_ph == M_OFFER) begin
            if (irq_ready_i) m_ph = M_WAIT;
         end else if (m_ph == M_WAIT) begin
            if (done_i) m_ph = M_WRITE;
         end else if (m_ph == M_WRITE) begin
            if (reg_ready_i) begin
               m_set = reg_error_i; m_ph = M_QUIET; m_quiet_cycles = 0;
            end
         end else begin
            m_quiet_cycles++;
            if (m_quiet_cycles == HOLDOFF) m_ph = M_IDLE;
         end
`ifdef PLIC_CLAIM_STATS_EN
         if (m_set && m_errs < 65535) m_errs++;
`endif
         if (m_set) m_err = 1'b1;
         else if (err_clr_i) m_err = 1'b0;
      end
   end

   // ---------------- compare process + scoreboard ----------------
   always @(negedge clk) begin
      logic on_bus;
      on_bus = (m_ph == M_READ) || (m_ph == M_WRITE);
      chk("reg_valid", {31'b0, reg_valid_o}, {31'b0, on_bus});
      chk("reg_write", {31'b0, reg_write_o}, {31'b0, m_ph == M_WRITE});
      chk("reg_addr", reg_addr_o, on_bus ? EXP_ADDR : 32'h0);
      chk("reg_wdata", reg_wdata_o, (m_ph == M_WRITE) ? 32'(m_id) : 32'h0);
      chk("reg_wstrb", {28'b0, reg_wstrb_o}, (m_ph == M_WRITE) ? 32'hF : 32'h0);
      chk("irq_valid", {31'b0, irq_valid_o}, {31'b0, m_ph == M_OFFER});
      if (m_ph == M_OFFER) chk("irq_id", {27'b0, irq_id_o}, 32'(m_id));
      chk("busy", {31'b0, busy_o},
          {31'b0, m_ph != M_IDLE && m_ph != M_QUIET});
      chk("err", {31'b0, err_o}, {31'b0, m_err});
`ifdef PLIC_CLAIM_STATS_EN
      chk("stat_claims", {16'b0, stat_claims_o}, 32'(m_claims));
      chk("stat_spurious", {16'b0, stat_spurious_o}, 32'(m_spur));
      chk("stat_errors", {16'b0, stat_errors_o}, 32'(m_errs));
`endif
      if (rst_ni && irq_valid_o && irq_ready_i) begin
         if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL sb_unexpected: got id %0d expected none", irq_id_o);
         end else begin
            chk("sb_id", {27'b0, irq_id_o}, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic bus_resp(input int waits, input logic [31:0] rd, input logic er,
                           input logic clr);
      int n = 0;
      while (!reg_valid_o && n < 100) begin tick(); n++; end
      if (!reg_valid_o) begin
         n_checks++; n_errors++;
         $display("FAIL bus_timeout: got no reg_valid_o expected request within 100 cycles");
         return;
      end
      repeat (waits) tick();
      reg_ready_i = 1'b1; reg_rdata_i = rd; reg_error_i = er; err_clr_i = clr;
      tick();
      reg_ready_i = 1'b0; reg_rdata_i = '0; reg_error_i = 1'b0; err_clr_i = 1'b0;
   endtask

   task automatic irq_accept(input int delay);
      int n = 0;
      while (!irq_valid_o && n < 100) begin tick(); n++; end
      if (!irq_valid_o) begin
         n_checks++; n_errors++;
         $display("FAIL irq_timeout: got no irq_valid_o expected offer within 100 cycles");
         return;
      end
      repeat (delay) tick();
      irq_ready_i = 1'b1;
      tick();
      irq_ready_i = 1'b0;
   endtask

   // Pulses done and checks the completion write appears on the very next cycle.
   task automatic do_done(input logic [31:0] id);
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      chk("write_latency", {31'b0, reg_valid_o}, 32'd1);
      chk("write_dir", {31'b0, reg_write_o}, 32'd1);
      chk("write_addr", reg_addr_o, EXP_ADDR);
      chk("write_data", reg_wdata_o, id);
      chk("write_strb", {28'b0, reg_wstrb_o}, 32'hF);
   endtask

   task automatic full_claim(input logic [31:0] rd, input logic [31:0] id);
      exp_q.push_back(id);
      bus_resp(0, rd, 1'b0, 1'b0);
      eip_i = 1'b0;
      irq_accept(0);
      do_done(id);
      bus_resp(0, 32'h0, 1'b0, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int gap;
      rst_ni = 1'b0; eip_i = 0; enable_i = 1; reg_ready_i = 0; reg_error_i = 0;
      reg_rdata_i = '0; irq_ready_i = 0; done_i = 0; err_clr_i = 0;
      repeat (3) tick();
      chk("rst_valid", {31'b0, reg_valid_o}, 32'd0);
      chk("rst_addr", reg_addr_o, 32'd0);
      chk("rst_irq", {31'b0, irq_valid_o}, 32'd0);
      chk("rst_busy", {31'b0, busy_o}, 32'd0);
      chk("rst_err", {31'b0, err_o}, 32'd0);
      rst_ni = 1'b1;
      repeat (2) tick();

      // Basic claim/complete of ID 7 with two bus wait cycles.
      eip_i = 1'b1;
      exp_q.push_back(32'd7);
      tick();
      chk("claim_latency", {31'b0, reg_valid_o}, 32'd1);
      chk("claim_addr", reg_addr_o, 32'h0C20_1004);
      chk("claim_read", {31'b0, reg_write_o}, 32'd0);
      bus_resp(2, 32'd7, 1'b0, 1'b0);
      eip_i = 1'b0;
      chk("dispatch_latency", {31'b0, irq_valid_o}, 32'd1);
      chk("dispatch_id", {27'b0, irq_id_o}, 32'd7);
      irq_accept(0);
      do_done(32'd7);
      bus_resp(0, 32'h0, 1'b0, 1'b0);
      chk("hold_not_busy", {31'b0, busy_o}, 32'd0);
      repeat (4) tick();

      // Back-to-back: eip held high over IDs 3 and 5; upper rdata bits must be ignored.
      eip_i = 1'b1;
      exp_q.push_back(32'd3);
      exp_q.push_back(32'd5);
      bus_resp(1, 32'hFFFF_FFE3, 1'b0, 1'b0);
      irq_accept(0);
      do_done(32'd3);
      bus_resp(0, 32'h0, 1'b0, 1'b0);
      gap = 0;
      while (!reg_valid_o && gap < 20) begin tick(); gap++; end
      // HOLDOFF quiet cycles, then one IDLE cycle that samples eip.
      chk("b2b_gap", 32'(gap), 32'(HOLDOFF + 1));
      bus_resp(0, 32'd5, 1'b0, 1'b0);
      eip_i = 1'b0;
      irq_accept(0);
      do_done(32'd5);
      bus_resp(0, 32'h0, 1'b0, 1'b0);
      repeat (4) tick();

      // Spurious claim: low ID bits zero, upper bits set.
      eip_i = 1'b1;
      bus_resp(0, 32'h1234_5660, 1'b0, 1'b0);
      eip_i = 1'b0;
      chk("spur_no_irq", {31'b0, irq_valid_o}, 32'd0);
      chk("spur_no_write", {31'b0, reg_valid_o}, 32'd0);
      repeat (4) tick();

      // Handler backpressure with a stray done during the offer.
      eip_i = 1'b1;
      exp_q.push_back(32'd9);
      bus_resp(0, 32'd9, 1'b0, 1'b0);
      eip_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", {31'b0, irq_valid_o}, 32'd1);
         chk("bp_id", {27'b0, irq_id_o}, 32'd9);
         done_i = (i == 4);
         tick();
      end
      done_i = 1'b0;
      irq_accept(0);
      chk("service_wait", {31'b0, reg_valid_o}, 32'd0);
      do_done(32'd9);
      bus_resp(0, 32'h0, 1'b0, 1'b0);
      repeat (4) tick();

      // Disabled agent ignores eip; disabling mid-operation does not abort.
      enable_i = 1'b0;
      eip_i = 1'b1;
      repeat (5) tick();
      chk("disabled_idle", {31'b0, reg_valid_o}, 32'd0);
      enable_i = 1'b1;
      tick();
      enable_i = 1'b0;
      full_claim(32'd4, 32'd4);
      enable_i = 1'b1;
      repeat (4) tick();

      // Bus error on the claim read, then clear.
      eip_i = 1'b1;
      bus_resp(0, 32'h11, 1'b1, 1'b0);
      eip_i = 1'b0;
      chk("rd_err_set", {31'b0, err_o}, 32'd1);
      chk("rd_err_no_irq", {31'b0, irq_valid_o}, 32'd0);
      repeat (3) tick();
      err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
      chk("err_cleared", {31'b0, err_o}, 32'd0);

      // Bus error on the completion write.
      eip_i = 1'b1;
      exp_q.push_back(32'd2);
      bus_resp(0, 32'd2, 1'b0, 1'b0);
      eip_i = 1'b0;
      irq_accept(0);
      do_done(32'd2);
      bus_resp(0, 32'h0, 1'b1, 1'b0);
      chk("wr_err_set", {31'b0, err_o}, 32'd1);
      repeat (4) tick();
      chk("wr_err_idle", {31'b0, busy_o}, 32'd0);
      err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;

      // Error and clear in the same cycle: the error wins.
      eip_i = 1'b1;
      bus_resp(0, 32'h0, 1'b1, 1'b1);
      eip_i = 1'b0;
      chk("set_beats_clr", {31'b0, err_o}, 32'd1);
      repeat (3) tick();
      err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;

      // Asynchronous reset while the completion write is pending.
      eip_i = 1'b1;
      exp_q.push_back(32'd6);
      bus_resp(0, 32'd6, 1'b0, 1'b0);
      eip_i = 1'b0;
      irq_accept(0);
      do_done(32'd6);
      #3;
      rst_ni = 1'b0;
      #1;
      chk("async_valid", {31'b0, reg_valid_o}, 32'd0);
      chk("async_write", {31'b0, reg_write_o}, 32'd0);
      chk("async_addr", reg_addr_o, 32'd0);
      chk("async_wdata", reg_wdata_o, 32'd0);
      chk("async_busy", {31'b0, busy_o}, 32'd0);
      repeat (2) tick();
      rst_ni = 1'b1;
      eip_i = 1'b1;
      tick();
      chk("fresh_claim", {31'b0, reg_valid_o}, 32'd1);
      full_claim(32'd8, 32'd8);
      repeat (4) tick();

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      n_checks++; n_errors++;
      $display("FAIL watchdog: got no end of test expected finish before 200000");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
